// File: rtl/dpe_pkg.sv
// dpe_pkg: shared types and defaults for the DPE egress demultiplexer.
//   dpe_demux_state_t : route FSM states (IDLE, FWD, DROP)
//   DPE_ADDR_BCAST    : default destination value that selects every output
package dpe_pkg;

  localparam int DPE_NUM_PORTS  = 5;
  localparam int DPE_DATA_W     = 128;
  localparam int DPE_ADDR_W     = 3;
  localparam int DPE_ADDR_BCAST = 7;
  localparam int DPE_CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } dpe_demux_state_t;

endpackage

// File: rtl/dpe_demux_fork.sv
// dpe_demux_fork: single-beat output buffer with an eager per-output fork.
// A loaded beat is presented on every output whose pend bit is set; each output
// clears its own pend bit on handshake, so a slow output never holds back the
// others. The buffer frees once all pend bits have cleared.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load, load_mask          store the beat_* fields, pend <= load_mask
//   beat_*                   beat fields to store (data/keep/last/tuser)
//   m_tvalid / m_tready      per-output handshake
//   m_tdata .. m_tuser_dst   shared registered beat
//   buf_vld                  buffer holds a beat
//   space                    buffer can take a new beat this clk (~buf_vld | done)
module dpe_demux_fork
  import dpe_pkg::*;
#(
  parameter int NUM_PORTS = DPE_NUM_PORTS,
  parameter int DATA_W    = DPE_DATA_W,
  parameter int ADDR_W    = DPE_ADDR_W,
  parameter int KEEP_W    = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [NUM_PORTS-1:0] load_mask,
  input  logic [DATA_W-1:0]    beat_tdata,
  input  logic [KEEP_W-1:0]    beat_tkeep,
  input  logic                 beat_tlast,
  input  logic                 beat_tuser_bypass_all,
  input  logic                 beat_tuser_bypass_stage,
  input  logic [ADDR_W-1:0]    beat_tuser_src,
  input  logic [ADDR_W-1:0]    beat_tuser_dst,
  output logic [NUM_PORTS-1:0] m_tvalid,
  input  logic [NUM_PORTS-1:0] m_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic [KEEP_W-1:0]    m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tuser_bypass_all,
  output logic                 m_tuser_bypass_stage,
  output logic [ADDR_W-1:0]    m_tuser_src,
  output logic [ADDR_W-1:0]    m_tuser_dst,
  output logic                 buf_vld,
  output logic                 space
);

  logic [NUM_PORTS-1:0] pend;
  logic                 done;

  assign m_tvalid = pend & {NUM_PORTS{buf_vld}};
  // Every still-pending output is taking the beat this clk.
  assign done     = buf_vld & ((pend & ~m_tready) == '0);
  assign space    = ~buf_vld | done;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld              <= 1'b0;
      pend                 <= '0;
      m_tdata              <= '0;
      m_tkeep              <= '0;
      m_tlast              <= 1'b0;
      m_tuser_bypass_all   <= 1'b0;
      m_tuser_bypass_stage <= 1'b0;
      m_tuser_src          <= '0;
      m_tuser_dst          <= '0;
    end else if (load) begin
      // load is only raised when space is set, so the old beat is fully taken.
      buf_vld              <= 1'b1;
      pend                 <= load_mask;
      m_tdata              <= beat_tdata;
      m_tkeep              <= beat_tkeep;
      m_tlast              <= beat_tlast;
      m_tuser_bypass_all   <= beat_tuser_bypass_all;
      m_tuser_bypass_stage <= beat_tuser_bypass_stage;
      m_tuser_src          <= beat_tuser_src;
      m_tuser_dst          <= beat_tuser_dst;
    end else begin
      pend <= pend & ~(m_tvalid & m_tready);
      if (done) begin
        buf_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dpe_demux_n.sv
// dpe_demux_n: N-port AXIS packet demultiplexer for the DPE egress path.
// The route is taken from s_tuser_dst on the first beat of each packet and held
// until tlast: dst < NUM_PORTS selects one output, dst == BCAST_ADDR selects all,
// anything else drops the whole packet (counted in drop_cnt).
// Optional feature macro: DPE_DEMUX_STATS_EN enables the saturating drop counter;
// without it drop_cnt is tied to zero.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_tvalid/s_tready, s_t*        input stream and sideband
//   m_tvalid/m_tready [NUM_PORTS]  per-output handshake
//   m_tdata .. m_tuser_dst         shared registered beat, common to all outputs
//   drop_cnt                       dropped-packet count
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// FWD   | mid-packet, beats go to the locked route
// DROP  | mid-packet with unmapped destination, beats discarded
module dpe_demux_n
  import dpe_pkg::*;
#(
  parameter int NUM_PORTS  = DPE_NUM_PORTS,
  parameter int DATA_W     = DPE_DATA_W,
  parameter int ADDR_W     = DPE_ADDR_W,
  parameter int BCAST_ADDR = DPE_ADDR_BCAST,
  parameter int CNT_W      = DPE_CNT_W,
  parameter int KEEP_W     = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic [KEEP_W-1:0]    s_tkeep,
  input  logic                 s_tlast,
  input  logic                 s_tuser_bypass_all,
  input  logic                 s_tuser_bypass_stage,
  input  logic [ADDR_W-1:0]    s_tuser_src,
  input  logic [ADDR_W-1:0]    s_tuser_dst,
  output logic [NUM_PORTS-1:0] m_tvalid,
  input  logic [NUM_PORTS-1:0] m_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic [KEEP_W-1:0]    m_tkeep,
  output logic                 m_tlast,
  output logic                 m_tuser_bypass_all,
  output logic                 m_tuser_bypass_stage,
  output logic [ADDR_W-1:0]    m_tuser_src,
  output logic [ADDR_W-1:0]    m_tuser_dst,
  output logic [CNT_W-1:0]     drop_cnt
);

  dpe_demux_state_t     state;
  logic [NUM_PORTS-1:0] route;
  logic [NUM_PORTS-1:0] first_mask;
  logic [NUM_PORTS-1:0] load_mask;
  logic                 mapped;
  logic                 accept;
  logic                 load;
  logic                 space;
  logic                 buf_vld;

  // Route implied by s_tuser_dst if the current beat is a first beat.
  always_comb begin
    first_mask = '0;
    mapped     = 1'b0;
    if (s_tuser_dst == ADDR_W'(BCAST_ADDR)) begin
      first_mask = '1;
      mapped     = 1'b1;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (s_tuser_dst == ADDR_W'(i)) begin
          first_mask[i] = 1'b1;
          mapped        = 1'b1;
        end
      end
    end
  end

  // Discarded beats never touch the buffer, so they are accepted even while
  // the buffer is still draining a previous packet.
  always_comb begin
    s_tready = 1'b1;
    case (state)
      IDLE:    s_tready = mapped ? space : 1'b1;
      FWD:     s_tready = space;
      DROP:    s_tready = 1'b1;
      default: s_tready = 1'b1;
    endcase
  end

  assign accept    = s_tvalid & s_tready;
  assign load      = accept & ((state == FWD) | ((state == IDLE) & mapped));
  assign load_mask = (state == FWD) ? route : first_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      route <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (mapped) begin
            route <= first_mask;
            if (!s_tlast) state <= FWD;
          end else if (!s_tlast) begin
            state <= DROP;
          end
        end
        FWD:     if (s_tlast) state <= IDLE;
        DROP:    if (s_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DPE_DEMUX_STATS_EN
  logic drop_evt;

  // A packet is dropped when its tlast is discarded, including a single-beat
  // unmapped packet seen in IDLE.
  assign drop_evt = accept & s_tlast &
                    ((state == DROP) | ((state == IDLE) & ~mapped));

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_evt && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

  dpe_demux_fork #(
    .NUM_PORTS (NUM_PORTS),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .KEEP_W    (KEEP_W)
  ) u_fork (
    .clk                     (clk),
    .rst                     (rst),
    .load                    (load),
    .load_mask               (load_mask),
    .beat_tdata              (s_tdata),
    .beat_tkeep              (s_tkeep),
    .beat_tlast              (s_tlast),
    .beat_tuser_bypass_all   (s_tuser_bypass_all),
    .beat_tuser_bypass_stage (s_tuser_bypass_stage),
    .beat_tuser_src          (s_tuser_src),
    .beat_tuser_dst          (s_tuser_dst),
    .m_tvalid                (m_tvalid),
    .m_tready                (m_tready),
    .m_tdata                 (m_tdata),
    .m_tkeep                 (m_tkeep),
    .m_tlast                 (m_tlast),
    .m_tuser_bypass_all      (m_tuser_bypass_all),
    .m_tuser_bypass_stage    (m_tuser_bypass_stage),
    .m_tuser_src             (m_tuser_src),
    .m_tuser_dst             (m_tuser_dst),
    .buf_vld                 (buf_vld),
    .space                   (space)
  );

endmodule

// File: tb/tb_dpe_demux_n.sv
module tb_dpe_demux_n;

  localparam int NP = 5;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int AW = 3;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          byp_all;
    logic          byp_stage;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser_bypass_all = 1'b0;
  logic          s_tuser_bypass_stage = 1'b0;
  logic [AW-1:0] s_tuser_src = '0;
  logic [AW-1:0] s_tuser_dst = '0;
  logic [NP-1:0] m_tvalid;
  logic [NP-1:0] m_tready = '1;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tuser_bypass_all;
  logic          m_tuser_bypass_stage;
  logic [AW-1:0] m_tuser_src;
  logic [AW-1:0] m_tuser_dst;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  int pkt_id = 0;
  int waits;

  beat_t exp_q [NP][$];

  always #5 clk = ~clk;

  dpe_demux_n dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_tvalid             (s_tvalid),
    .s_tready             (s_tready),
    .s_tdata              (s_tdata),
    .s_tkeep              (s_tkeep),
    .s_tlast              (s_tlast),
    .s_tuser_bypass_all   (s_tuser_bypass_all),
    .s_tuser_bypass_stage (s_tuser_bypass_stage),
    .s_tuser_src          (s_tuser_src),
    .s_tuser_dst          (s_tuser_dst),
    .m_tvalid             (m_tvalid),
    .m_tready             (m_tready),
    .m_tdata              (m_tdata),
    .m_tkeep              (m_tkeep),
    .m_tlast              (m_tlast),
    .m_tuser_bypass_all   (m_tuser_bypass_all),
    .m_tuser_bypass_stage (m_tuser_bypass_stage),
    .m_tuser_src          (m_tuser_src),
    .m_tuser_dst          (m_tuser_dst),
    .drop_cnt             (drop_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic beat_t mk_beat(input int pid, input int b, input int n,
                                    input bit close, input logic [AW-1:0] dst);
    beat_t e;
    e.data      = {4{pid[15:0], b[15:0]}};
    e.last      = close && (b == n - 1);
    e.keep      = e.last ? 16'h00FF : 16'hFFFF;
    e.byp_all   = b[0];
    e.byp_stage = b[1];
    e.src       = pid[AW-1:0];
    e.dst       = dst;
    return e;
  endfunction

  // Drive one packet. Expected mask is given by hand per call; the expected
  // beat is queued for each targeted output when the DUT accepts it.
  task automatic send_pkt(input logic [AW-1:0] d0, input logic [AW-1:0] drest,
                          input int n, input logic [NP-1:0] mask, input bit close,
                          output int nwait);
    beat_t e;
    int t;
    nwait = 0;
    pkt_id++;
    for (int b = 0; b < n; b++) begin
      e = mk_beat(pkt_id, b, n, close, (b == 0) ? d0 : drest);
      s_tvalid             = 1'b1;
      s_tdata              = e.data;
      s_tkeep              = e.keep;
      s_tlast              = e.last;
      s_tuser_bypass_all   = e.byp_all;
      s_tuser_bypass_stage = e.byp_stage;
      s_tuser_src          = e.src;
      s_tuser_dst          = e.dst;
      @(negedge clk);
      t = 0;
      while (!s_tready && t < 100) begin
        nwait++;
        t++;
        @(negedge clk);
      end
      if (t >= 100) begin
        checks++;
        failures++;
        $display("FAIL s_tready_timeout: got 0 expected 1 at %0t", $time);
      end
      for (int i = 0; i < NP; i++)
        if (mask[i]) exp_q[i].push_back(e);
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin
    beat_t e, a;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        if (m_tvalid[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid port %0d: got valid=1 expected valid=0 at %0t", i, $time);
          end else if (m_tready[i]) begin
            e = exp_q[i].pop_front();
            a = '{m_tdata, m_tkeep, m_tlast, m_tuser_bypass_all,
                  m_tuser_bypass_stage, m_tuser_src, m_tuser_dst};
            checks++;
            if (a !== e) begin
              failures++;
              $display("FAIL beat port %0d: got %0h expected %0h at %0t", i, a, e, $time);
            end
          end
        end
      end
    end
  end

  initial begin
    int exp_drop;
`ifdef DPE_DEMUX_STATS_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_m_tvalid", DW'(m_tvalid), '0);
    chk("reset_m_tdata", m_tdata, '0);
    chk("reset_drop_cnt", DW'(drop_cnt), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_s_tready", DW'(s_tready), 1);
    @(posedge clk);
    #1;

    // 1: unicast 4 beats to output 2
    fork
      send_pkt(3'd2, 3'd2, 4, 5'b00100, 1'b1, waits);
      begin
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("t1_m_tvalid", DW'(m_tvalid), DW'(5'b00100));
          chk("t1_m_tlast", DW'(m_tlast), DW'(k == 3));
        end
      end
    join
    chk("t1_no_stall", DW'(waits), 0);
    repeat (2) @(posedge clk);
    #1;

    // 2: route locked on beat 0 although dst changes to 3
    send_pkt(3'd1, 3'd3, 4, 5'b00010, 1'b1, waits);
    repeat (2) @(posedge clk);
    #1;

    // 3: broadcast with output 3 stalled for 3 clks
    m_tready = 5'b10111;
    fork
      send_pkt(3'd7, 3'd7, 2, 5'b11111, 1'b1, waits);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("t3_clk1_valid", DW'(m_tvalid), DW'(5'b11111));
        chk("t3_clk1_s_tready", DW'(s_tready), 0);
        for (int k = 2; k <= 3; k++) begin
          @(negedge clk);
          chk("t3_stall_valid", DW'(m_tvalid), DW'(5'b01000));
          chk("t3_stall_s_tready", DW'(s_tready), 0);
        end
        @(posedge clk);
        #1 m_tready = 5'b11111;
        @(negedge clk);
        chk("t3_clk4_valid", DW'(m_tvalid), DW'(5'b01000));
        chk("t3_clk4_s_tready", DW'(s_tready), 1);
        @(negedge clk);
        chk("t3_beat1_valid", DW'(m_tvalid), DW'(5'b11111));
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // 4: unmapped dst=6 dropped, then dst=0 delivered
    chk("t4_drop_cnt_before", DW'(drop_cnt), 0);
    send_pkt(3'd6, 3'd6, 3, 5'b00000, 1'b1, waits);
    chk("t4_drop_no_stall", DW'(waits), 0);
    @(negedge clk);
    chk("t4_drop_cnt_after", DW'(drop_cnt), DW'(exp_drop));
    @(posedge clk);
    #1;
    send_pkt(3'd0, 3'd0, 2, 5'b00001, 1'b1, waits);
    repeat (2) @(posedge clk);
    #1;

    // 5: reset on beat 2 of a 5-beat dst=4 packet
    send_pkt(3'd4, 3'd4, 2, 5'b10000, 1'b0, waits);
    s_tvalid = 1'b1;
    s_tdata  = '1;
    s_tlast  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("t5_m_tvalid_after_rst", DW'(m_tvalid), '0);
    chk("t5_s_tready_after_rst", DW'(s_tready), 1);
    chk("t5_drop_cnt_after_rst", DW'(drop_cnt), 0);
    chk("t5_m_tdata_after_rst", m_tdata, '0);
    @(posedge clk);
    #1;
    send_pkt(3'd0, 3'd0, 1, 5'b00001, 1'b1, waits);
    repeat (2) @(posedge clk);
    #1;

    // 6: back-to-back single-beat packets dst 0, 1, 7
    fork
      begin
        send_pkt(3'd0, 3'd0, 1, 5'b00001, 1'b1, waits);
        send_pkt(3'd1, 3'd1, 1, 5'b00010, 1'b1, waits);
        send_pkt(3'd7, 3'd7, 1, 5'b11111, 1'b1, waits);
      end
      begin
        @(posedge clk);
        @(negedge clk);
        chk("t6_valid0", DW'(m_tvalid), DW'(5'b00001));
        @(negedge clk);
        chk("t6_valid1", DW'(m_tvalid), DW'(5'b00010));
        @(negedge clk);
        chk("t6_valid2", DW'(m_tvalid), DW'(5'b11111));
      end
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_idle_valid", DW'(m_tvalid), '0);
    for (int i = 0; i < NP; i++)
      chk($sformatf("final_queue_empty_%0d", i), DW'(exp_q[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
